// File: rtl/dcache_mem_pkg.sv
//------------------------------------------------------------------------------
// dcache_mem_pkg : shared widths, line type and read-FSM states for the
//                  DRAM-side memory responder model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dcache_mem_pkg;

    localparam int ADDR_W    = 64;
    localparam int ID_W      = 16;
    localparam int DATA_W    = 512;
    localparam int TAG_S     = 64;
    localparam int INDEX_W   = 10;
    localparam int INDEX_LSB = 38;
    localparam int LINE_W    = TAG_S + DATA_W;
    localparam int DEPTH     = 2 ** INDEX_W;

    typedef logic [LINE_W-1:0]  line_t;
    typedef logic [INDEX_W-1:0] index_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_RESP = 2'd2
    } r_state_t;

    function automatic index_t addr_to_index(input logic [ADDR_W-1:0] addr);
        return addr[INDEX_LSB +: INDEX_W];
    endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_store.sv
//------------------------------------------------------------------------------
// dcache_line_store : one line per index, per-line valid vector, one write
//                     port and one forwarding combinational read port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dcache_line_store
    import dcache_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   we,
    input  index_t waddr,
    input  line_t  wdata,
    input  index_t raddr,
    output line_t  rdata
);

    line_t             mem_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  valid_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (we) begin
            valid_d[waddr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // A same-index write in this cycle wins so a concurrent capture sees the new line.
    always_comb begin
        if (we && (waddr == raddr)) begin
            rdata = wdata;
        end else if (valid_q[raddr]) begin
            rdata = mem_q[raddr];
        end else begin
            rdata = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dcache_mem_responder.sv
//------------------------------------------------------------------------------
// dcache_mem_responder : memory-side responder for the DRAM cache controller;
//                        fixed-latency reads, AW/W-joined writes with B reply.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dcache_mem_responder
    import dcache_mem_pkg::*;
#(
    parameter int RD_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   m_arid_i,
    input  logic [ADDR_W-1:0] m_araddr_i,
    input  logic              m_arvalid_i,
    output logic              m_arready_o,
    output logic [ID_W-1:0]   m_rid_o,
    output logic [LINE_W-1:0] m_rdata_o,
    output logic              m_rvalid_o,
    input  logic              m_rready_i,
    input  logic [ID_W-1:0]   m_awid_i,
    input  logic [ADDR_W-1:0] m_awaddr_i,
    input  logic              m_awvalid_i,
    output logic              m_awready_o,
    input  logic [ID_W-1:0]   m_wid_i,
    input  logic [LINE_W-1:0] m_wdata_i,
    input  logic              m_wvalid_i,
    output logic              m_wready_o,
    output logic [ID_W-1:0]   m_bid_o,
    output logic              m_bvalid_o,
    input  logic              m_bready_i
);

    localparam int              CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    // Read path state
    r_state_t          r_state_q, r_state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    index_t            r_idx_q, r_idx_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    line_t             rdata_q, rdata_d;
    logic              capture;
    index_t            rd_index;
    line_t             rd_line;

    // Write path state
    logic              aw_full_q, aw_full_d;
    index_t            aw_idx_q, aw_idx_d;
    logic [ID_W-1:0]   aw_id_q, aw_id_d;
    logic              w_full_q, w_full_d;
    line_t             w_data_q, w_data_d;
    logic              b_pend_q, b_pend_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic              aw_hs, w_hs, commit;
    index_t            wr_index;
    line_t             wr_line;

    logic              unused_bits;
    assign unused_bits = ^{m_wid_i, m_araddr_i, m_awaddr_i};

    assign m_arready_o = (r_state_q == R_IDLE);
    assign m_rvalid_o  = (r_state_q == R_RESP);
    assign m_rid_o     = rid_q;
    assign m_rdata_o   = rdata_q;

    assign m_awready_o = !aw_full_q && !b_pend_q;
    assign m_wready_o  = !w_full_q && !b_pend_q;
    assign m_bvalid_o  = b_pend_q;
    assign m_bid_o     = bid_q;

    // In R_IDLE the index comes straight from the bus so RD_LAT=1 can capture on the AR edge.
    assign rd_index = (r_state_q == R_IDLE) ? addr_to_index(m_araddr_i) : r_idx_q;

    always_comb begin
        r_state_d = r_state_q;
        cnt_d     = cnt_q;
        r_idx_d   = r_idx_q;
        rid_d     = rid_q;
        capture   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (m_arvalid_i) begin
                    rid_d   = m_arid_i;
                    r_idx_d = rd_index;
                    cnt_d   = CNT_LOAD;
                    if (RD_LAT == 1) begin
                        capture   = 1'b1;
                        r_state_d = R_RESP;
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (cnt_q == '0) begin
                    capture   = 1'b1;
                    r_state_d = R_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (m_rready_i) begin
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (capture) begin
            rdata_d = rd_line;
        end
    end

    assign aw_hs    = m_awvalid_i && m_awready_o;
    assign w_hs     = m_wvalid_i && m_wready_o;
    assign wr_index = aw_full_q ? aw_idx_q : addr_to_index(m_awaddr_i);
    assign wr_line  = w_full_q ? w_data_q : m_wdata_i;
    assign commit   = (aw_full_q || aw_hs) && (w_full_q || w_hs);

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        aw_id_d   = aw_id_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        b_pend_d  = b_pend_q;
        bid_d     = bid_q;
        if (b_pend_q && m_bready_i) begin
            b_pend_d = 1'b0;
        end
        // Readies are low while B is pending, so a commit never overlaps a B handshake.
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            b_pend_d  = 1'b1;
            bid_d     = aw_full_q ? aw_id_q : m_awid_i;
        end else begin
            if (aw_hs) begin
                aw_full_d = 1'b1;
                aw_idx_d  = wr_index;
                aw_id_d   = m_awid_i;
            end
            if (w_hs) begin
                w_full_d = 1'b1;
                w_data_d = m_wdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            cnt_q     <= '0;
            r_idx_q   <= '0;
            rid_q     <= '0;
            rdata_q   <= '0;
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            aw_id_q   <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            b_pend_q  <= 1'b0;
            bid_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            cnt_q     <= cnt_d;
            r_idx_q   <= r_idx_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            aw_id_q   <= aw_id_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            b_pend_q  <= b_pend_d;
            bid_q     <= bid_d;
        end
    end

    dcache_line_store u_store (
        .clk   (clk),
        .rst   (rst),
        .we    (commit),
        .waddr (wr_index),
        .wdata (wr_line),
        .raddr (rd_index),
        .rdata (rd_line)
    );

endmodule

`default_nettype wire
